div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative integer divide/remainder function unit.
- Receives register-read bundles from the execute stage.
- Computes RV64M DIV/DIVU/REM/REMU and their W variants using a 1-bit-per-cycle restoring divider.
- Presents the result as a response on its fu_resp lanes and holds it until the execute-stage result arbiter claims it.
- It is the responder end of the fu_resp/fu_claim handshake.

Parameters:
- ewd, 4, execute width: number of request lanes and response lanes.
- fuid, 3, function-unit code; a request is for this unit when its fu field equals fuid.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous active-high
- req  input  reg_bundle_t[ewd-1:0]  operation bundles; a lane is valid when opid[15]=1 and fu==fuid
- busy  output  1  unit cannot accept a request this cycle
- fu_resp  output  exe_bundle_t[ewd-1:0]  result lanes; only lane 0 is ever used
- fu_claim  input  [ewd-1:0]  arbiter claim; only bit 0 is honoured

Behaviour:
- Reset:
  - state=IDLE, busy=0.
  - fu_resp all zero, so opid[15]=0 on every lane.
  - Internal quotient, remainder and counter cleared.
  - Reset mid-operation abandons the operation; no response is produced.
- Funct decode:
  - funct[1:0]: 00=DIV, 01=DIVU, 10=REM, 11=REMU.
  - funct[2]=1 selects the W variant.
- Operands: a=prs[0] is the dividend; b=prs[1] is the divisor.
- W-variant operand preparation:
  - Signed ops sign-extend the low 32 bits to 64 bits.
  - Unsigned ops zero-extend the low 32 bits.
- W-variant result: the low 32 bits of the result are sign-extended to 64 bits.
- Request accept:
  - Only in IDLE.
  - The lowest-index valid matching lane is taken; other matching lanes that cycle are ignored.
  - The issuer must respect busy; a request presented while busy is dropped.
  - busy=1 in every state except IDLE.
- Latched at accept: opid, prda, funct, operands.
- Signed ops: divide on absolute values; result sign fixed at the end.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- State machine:
  - IDLE -> CALC: on accept of a normal request.
  - IDLE -> DONE: on accept of a special case; the result is produced in the accept cycle.
  - CALC: one quotient bit per cycle, MSB first. Iterations = 64 for 64-bit ops, 32 for W ops.
  - CALC -> DONE: after the last iteration, with the sign fix applied combinationally into the response register.
  - DONE -> IDLE: the cycle after fu_claim[0]=1.
- Special cases:
  - Divide by zero: quotient = all ones (-1); remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
  - For W ops, the overflow check uses the 32-bit most-negative value 0x80000000.
- Latency, accept to response visible:
  - Normal 64-bit op: 65 cycles.
  - Normal W op: 33 cycles.
  - Special case: 1 cycle.
- Response contents, in DONE:
  - fu_resp[0].opid = latched opid, with bit 15 set.
  - fu_resp[0].prda = latched prda.
  - Result field = quotient or remainder, selected by funct[1].
  - All other lanes remain zero.
- Hold rule: in DONE the response is held unchanged every cycle until fu_claim[0]=1.
- After claim:
  - On the following cycle, fu_resp[0]=0 and state=IDLE.
  - A new request can be accepted no earlier than that cycle; there is no same-cycle claim-and-accept.
- fu_claim bits:
  - fu_claim[0] outside DONE is ignored.
  - fu_claim[ewd-1:1] are always ignored.

Test Plan:
- Reset, then DIVU a=100 b=7 on lane 2 -> busy on the next cycle; 65 cycles later fu_resp[0] holds result 14 with the correct opid and prda; lanes 1-3 are zero.
- REM a=-7 b=2, held unclaimed for 10 cycles -> result 0xFFFF_FFFF_FFFF_FFFF (-1) is stable every cycle; claim clears it the next cycle and busy drops.
- DIV a=5 b=0 -> response after 1 cycle = 0xFFFF_FFFF_FFFF_FFFF. REMU a=5 b=0 -> response = 5.
- DIV a=0x8000_0000_0000_0000 b=-1 -> quotient 0x8000_0000_0000_0000. DIVW with a low word of 0x80000000 and b=-1 -> 0xFFFF_FFFF_8000_0000. Both after 1 cycle.
- DIVUW a=0xFFFF_FFFF b=1 -> after 33 cycles, result 0xFFFF_FFFF_FFFF_FFFF (sign-extended).
- Matching requests on lanes 0 and 3 in the same cycle -> lane 0 accepted, lane 3 dropped. Assert rst mid-CALC -> no response ever appears and busy=0 after reset.

Source files
------------

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- iterative integer divide / remainder function unit
//
// Executes RV64M DIV, DIVU, REM, REMU and their 32-bit W variants with a
// restoring divider that retires one quotient bit per clock.  Requests arrive
// as register-read bundles on the execute-stage lanes; the result is
// presented on response lane 0 and held until the result arbiter claims it.
//
// Ports
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   req       in   ewd request lanes; valid when opid[15]=1 and fu==fuid
//   busy      out  unit cannot accept a request this cycle
//   fu_resp   out  ewd response lanes; only lane 0 is ever driven non-zero
//   fu_claim  in   arbiter claim; only bit 0 is honoured, and only in DONE
// -----------------------------------------------------------------------------

package div_unit_pkg;

    // Register-read bundle delivered by the execute stage.
    // funct[1:0]: 00=DIV 01=DIVU 10=REM 11=REMU, funct[2]: W variant.
    typedef struct packed {
        logic [15:0]      opid;
        logic [2:0]       fu;
        logic [2:0]       funct;
        logic [6:0]       prda;
        logic [1:0][63:0] prs;   // prs[0] dividend, prs[1] divisor
    } reg_bundle_t;

    // Function-unit response bundle.
    typedef struct packed {
        logic [15:0] opid;
        logic [6:0]  prda;
        logic [63:0] res;
    } exe_bundle_t;

endpackage

module div_unit
    import div_unit_pkg::*;
#(
    parameter int         ewd  = 4,
    parameter logic [2:0] fuid = 3'd3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  reg_bundle_t [ewd-1:0] req,
    output logic                  busy,
    output exe_bundle_t [ewd-1:0] fu_resp,
    input  logic [ewd-1:0]        fu_claim
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // W ops only look at the low word: signed ops sign-extend it, unsigned
    // ops zero-extend it.
    function automatic logic [63:0] prep_op(input logic [63:0] v,
                                            input logic        is_w,
                                            input logic        is_sgn);
        logic [63:0] r;
        if (!is_w) begin
            r = v;
        end else if (is_sgn) begin
            r = sext32(v[31:0]);
        end else begin
            r = {32'd0, v[31:0]};
        end
        return r;
    endfunction

    function automatic logic [63:0] neg_if(input logic [63:0] v, input logic en);
        return en ? (64'd0 - v) : v;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    exe_bundle_t [ewd-1:0] resp_q, resp_d;
    logic [15:0]           opid_q, opid_d;
    logic [6:0]            prda_q, prda_d;
    logic                  w_q, w_d;        // W variant
    logic                  rsel_q, rsel_d;  // 1 = remainder result
    logic                  qneg_q, qneg_d;  // negate quotient at the end
    logic                  rneg_q, rneg_d;  // negate remainder at the end
    logic [63:0]           dvd_q, dvd_d;    // dividend magnitude, shifted out MSB first
    logic [63:0]           dvs_q, dvs_d;    // divisor magnitude
    logic [63:0]           quo_q, quo_d;
    logic [63:0]           rem_q, rem_d;
    logic [5:0]            cnt_q, cnt_d;    // iterations left minus one

    // ------------------------------------------------------------------
    // Request lane selection
    // ------------------------------------------------------------------
    logic        sel_vld_s;
    logic [15:0] sel_opid_s;
    logic [2:0]  sel_funct_s;
    logic [6:0]  sel_prda_s;
    logic [63:0] sel_a_s;
    logic [63:0] sel_b_s;
    logic        claim_unused_s;

    assign claim_unused_s = ^fu_claim[ewd-1:1];

    // Pick the lowest-index lane holding a valid request for this unit;
    // scanning downward lets the lowest match overwrite any higher one.
    always_comb begin
        sel_vld_s   = 1'b0;
        sel_opid_s  = 16'd0;
        sel_funct_s = 3'd0;
        sel_prda_s  = 7'd0;
        sel_a_s     = 64'd0;
        sel_b_s     = 64'd0;
        for (int i = ewd - 1; i >= 0; i--) begin
            if (req[i].opid[15] && (req[i].fu == fuid)) begin
                sel_vld_s   = 1'b1;
                sel_opid_s  = req[i].opid;
                sel_funct_s = req[i].funct;
                sel_prda_s  = req[i].prda;
                sel_a_s     = req[i].prs[0];
                sel_b_s     = req[i].prs[1];
            end else begin
                sel_vld_s   = sel_vld_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand preparation and special-case detection for the selected lane
    // ------------------------------------------------------------------
    logic        acc_w_s;
    logic        acc_sgn_s;
    logic [63:0] a_prep_s;
    logic [63:0] b_prep_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [63:0] a_mag_s;
    logic [63:0] b_mag_s;
    logic        div0_s;
    logic        ovf_s;
    logic [63:0] sp_res_s;

    // Decode, prepare operands and compute the result of the one-cycle
    // special cases (divide by zero, signed overflow).
    always_comb begin
        acc_w_s   = sel_funct_s[2];
        acc_sgn_s = ~sel_funct_s[0];
        a_prep_s  = prep_op(sel_a_s, acc_w_s, acc_sgn_s);
        b_prep_s  = prep_op(sel_b_s, acc_w_s, acc_sgn_s);
        a_neg_s   = acc_sgn_s & a_prep_s[63];
        b_neg_s   = acc_sgn_s & b_prep_s[63];
        a_mag_s   = neg_if(a_prep_s, a_neg_s);
        b_mag_s   = neg_if(b_prep_s, b_neg_s);
        div0_s    = (b_prep_s == 64'd0);
        // W operands are already sign-extended, so the 32-bit most-negative
        // value shows up as its 64-bit sign extension.
        ovf_s     = acc_sgn_s && (b_prep_s == 64'hFFFF_FFFF_FFFF_FFFF) &&
                    (a_prep_s == (acc_w_s ? 64'hFFFF_FFFF_8000_0000
                                          : 64'h8000_0000_0000_0000));
        if (div0_s) begin
            sp_res_s = sel_funct_s[1] ? a_prep_s : 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            sp_res_s = sel_funct_s[1] ? 64'd0 : a_prep_s;
        end
        if (acc_w_s) begin
            sp_res_s = sext32(sp_res_s[31:0]);
        end else begin
            sp_res_s = sp_res_s;
        end
    end

    // ------------------------------------------------------------------
    // One restoring-division step and the final result
    // ------------------------------------------------------------------
    logic [64:0] rem_shift_s;
    logic [64:0] diff_s;
    logic        qbit_s;
    logic [63:0] rem_next_s;
    logic [63:0] quo_next_s;
    logic [63:0] fin_res_s;

    // Shift the next dividend bit into the partial remainder and subtract
    // the divisor when it fits; the remainder never exceeds 64 bits after
    // the step because it stays below the divisor.
    always_comb begin
        rem_shift_s = {rem_q, dvd_q[63]};
        diff_s      = rem_shift_s - {1'b0, dvs_q};
        qbit_s      = ~diff_s[64];
        if (qbit_s) begin
            rem_next_s = diff_s[63:0];
        end else begin
            rem_next_s = rem_shift_s[63:0];
        end
        quo_next_s = {quo_q[62:0], qbit_s};
        fin_res_s  = rsel_q ? neg_if(rem_next_s, rneg_q) : neg_if(quo_next_s, qneg_q);
        if (w_q) begin
            fin_res_s = sext32(fin_res_s[31:0]);
        end else begin
            fin_res_s = fin_res_s;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath next state
    // ------------------------------------------------------------------
    // IDLE accepts, CALC iterates, DONE holds the response until claimed.
    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        opid_d  = opid_q;
        prda_d  = prda_q;
        w_d     = w_q;
        rsel_d  = rsel_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (sel_vld_s) begin
                    opid_d = sel_opid_s;
                    prda_d = sel_prda_s;
                    w_d    = acc_w_s;
                    rsel_d = sel_funct_s[1];
                    qneg_d = a_neg_s ^ b_neg_s;
                    rneg_d = a_neg_s;
                    // W dividends fit in 32 bits; park them in the upper
                    // half so 32 MSB-first steps consume exactly them.
                    dvd_d  = acc_w_s ? {a_mag_s[31:0], 32'd0} : a_mag_s;
                    dvs_d  = b_mag_s;
                    quo_d  = 64'd0;
                    rem_d  = 64'd0;
                    cnt_d  = acc_w_s ? 6'd31 : 6'd63;
                    if (div0_s || ovf_s) begin
                        resp_d[0].opid = sel_opid_s | 16'h8000;
                        resp_d[0].prda = sel_prda_s;
                        resp_d[0].res  = sp_res_s;
                        state_d        = ST_DONE;
                    end else begin
                        state_d        = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                dvd_d = {dvd_q[62:0], 1'b0};
                quo_d = quo_next_s;
                rem_d = rem_next_s;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd0) begin
                    resp_d[0].opid = opid_q | 16'h8000;
                    resp_d[0].prda = prda_q;
                    resp_d[0].res  = fin_res_s;
                    state_d        = ST_DONE;
                end else begin
                    state_d        = ST_CALC;
                end
            end
            ST_DONE: begin
                if (fu_claim[0]) begin
                    resp_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                resp_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            resp_q  <= '0;
            opid_q  <= 16'd0;
            prda_q  <= 7'd0;
            w_q     <= 1'b0;
            rsel_q  <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dvd_q   <= 64'd0;
            dvs_q   <= 64'd0;
            quo_q   <= 64'd0;
            rem_q   <= 64'd0;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            resp_q  <= resp_d;
            opid_q  <= opid_d;
            prda_q  <= prda_d;
            w_q     <= w_d;
            rsel_q  <= rsel_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy    = busy_q;
    assign fu_resp = resp_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- scoreboard bench for div_unit
//
// A stimulus process issues directed and random requests and pushes the
// expected response (computed with plain SystemVerilog arithmetic) into a
// queue.  A monitor process watches response lane 0, pops and compares,
// checks latency, hold stability and lane clearing, and claims results.
// -----------------------------------------------------------------------------
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int         EWD  = 4;
    localparam logic [2:0] FUID = 3'd3;

    logic                  clk;
    logic                  rst;
    logic                  busy;
    reg_bundle_t [EWD-1:0] req;
    exe_bundle_t [EWD-1:0] fu_resp;
    logic [EWD-1:0]        fu_claim;

    int cyc   = 0;
    int n_vec = 0;
    int n_mis = 0;

    typedef struct {
        logic [15:0] opid;
        logic [6:0]  prda;
        logic [63:0] res;
        int          exp_cyc;
        int          dly;
    } exp_t;

    exp_t sb_q[$];

    div_unit #(.ewd(EWD), .fuid(FUID)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .busy     (busy),
        .fu_resp  (fu_resp),
        .fu_claim (fu_claim)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [63:0] model(input logic [2:0] f, input logic [63:0] a,
                                         input logic [63:0] b);
        int              sa, sb;
        int unsigned     ua, ub;
        longint          la, lb;
        longint unsigned qa, qb;
        logic [31:0]     r32;
        logic [63:0]     r64;
        bit              ovf32, ovf64;
        sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
        la = a; lb = b; qa = a; qb = b;
        ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
        ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        r32 = 32'd0;
        r64 = 64'd0;
        if (f[2]) begin
            case (f[1:0])
                2'b00: begin
                    if (sb == 0) r32 = 32'hFFFF_FFFF;
                    else if (ovf32) r32 = a[31:0];
                    else r32 = sa / sb;
                end
                2'b01: r32 = (ub == 0) ? 32'hFFFF_FFFF : ua / ub;
                2'b10: begin
                    if (sb == 0) r32 = a[31:0];
                    else if (ovf32) r32 = 32'd0;
                    else r32 = sa % sb;
                end
                default: r32 = (ub == 0) ? a[31:0] : ua % ub;
            endcase
            return {{32{r32[31]}}, r32};
        end
        case (f[1:0])
            2'b00: begin
                if (lb == 0) r64 = 64'hFFFF_FFFF_FFFF_FFFF;
                else if (ovf64) r64 = a;
                else r64 = la / lb;
            end
            2'b01: r64 = (qb == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : qa / qb;
            2'b10: begin
                if (lb == 0) r64 = a;
                else if (ovf64) r64 = 64'd0;
                else r64 = la % lb;
            end
            default: r64 = (qb == 0) ? a : qa % qb;
        endcase
        return r64;
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [63:0] a,
                                   input logic [63:0] b);
        bit special;
        if (f[2])
            special = (b[31:0] == 32'd0) ||
                      (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        else
            special = (b == 64'd0) ||
                      (!f[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
        if (special) return 1;
        return f[2] ? 33 : 65;
    endfunction

    function automatic reg_bundle_t mk(input logic [15:0] opid, input logic [2:0] fu,
                                       input logic [2:0] f, input logic [6:0] prda,
                                       input logic [63:0] a, input logic [63:0] b);
        reg_bundle_t r;
        r.opid   = opid;
        r.fu     = fu;
        r.funct  = f;
        r.prda   = prda;
        r.prs[0] = a;
        r.prs[1] = b;
        return r;
    endfunction

    task automatic drive(input reg_bundle_t [EWD-1:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
        req = '0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        n_vec++;
        n_mis++;
        $display("FAIL wait_idle: busy still 1 after 300 cycles, expected 0");
    endtask

    // Issue one request on 'lane'; optionally add a second matching request
    // on a higher lane (must be dropped) and a non-matching decoy lane.
    task automatic issue(input int lane, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] b, input int dly, input int extra_lane,
                         input int decoy_lane);
        reg_bundle_t [EWD-1:0] r;
        exp_t                  e;
        logic [15:0]           opid;
        logic [6:0]            prda;
        opid = {1'b1, 15'($urandom)};
        prda = 7'($urandom);
        r = '0;
        r[lane] = mk(opid, FUID, f, prda, a, b);
        if (extra_lane >= 0)
            r[extra_lane] = mk({1'b1, 15'($urandom)}, FUID, 3'b001, 7'd5, 64'd9, 64'd0);
        if (decoy_lane >= 0)
            r[decoy_lane] = mk({1'b1, 15'($urandom)}, FUID + 3'd1, 3'b000, 7'd9, 64'd1, 64'd0);
        wait_idle();
        drive(r);
        e.opid    = opid;
        e.prda    = prda;
        e.res     = model(f, a, b);
        e.exp_cyc = cyc + latency(f, a, b) - 1;
        e.dly     = dly;
        sb_q.push_back(e);
        chk("busy_after_accept", busy, 1'b1);
    endtask

    // Monitor / claimer.
    initial begin
        bit          holding;
        bit          claimed_last;
        int          hold_cnt;
        exe_bundle_t held;
        exp_t        e;
        holding      = 1'b0;
        claimed_last = 1'b0;
        hold_cnt     = 0;
        held         = '0;
        fu_claim     = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                holding      = 1'b0;
                claimed_last = 1'b0;
                fu_claim     = '0;
            end else begin
                if (claimed_last) begin
                    chk("cleared_after_claim", {fu_resp[0].opid, fu_resp[0].res[47:0]}, 64'd0);
                    chk("busy_after_claim", busy, 1'b0);
                    claimed_last = 1'b0;
                end
                if (fu_resp[0].opid[15]) begin
                    if (!holding) begin
                        if (sb_q.size() == 0) begin
                            n_vec++;
                            n_mis++;
                            $display("FAIL unexpected_resp: got opid %h res %h, expected no response",
                                     fu_resp[0].opid, fu_resp[0].res);
                            holding  = 1'b1;
                            hold_cnt = 0;
                        end else begin
                            e = sb_q.pop_front();
                            chk("resp_opid", fu_resp[0].opid, e.opid);
                            chk("resp_prda", fu_resp[0].prda, e.prda);
                            chk("resp_result", fu_resp[0].res, e.res);
                            chk("resp_latency_cycle", cyc, e.exp_cyc);
                            holding  = 1'b1;
                            hold_cnt = e.dly;
                        end
                        held = fu_resp[0];
                    end else begin
                        chk("hold_stable", fu_resp[0] == held, 1'b1);
                    end
                    for (int i = 1; i < EWD; i++)
                        chk("unused_lane_zero", fu_resp[i] == '0, 1'b1);
                    if (hold_cnt == 0) begin
                        fu_claim[0]  = 1'b1;
                        holding      = 1'b0;
                        claimed_last = 1'b1;
                    end else begin
                        hold_cnt--;
                        fu_claim[0] = 1'b0;
                    end
                end else begin
                    if (holding) begin
                        chk("resp_dropped_unclaimed", 1'b0, 1'b1);
                        holding = 1'b0;
                    end
                    fu_claim[0] = 1'($urandom_range(0, 1));
                end
                fu_claim[EWD-1:1] = (EWD-1)'($urandom);
            end
        end
    end

    // Stimulus.
    initial begin
        reg_bundle_t [EWD-1:0] r;
        logic [2:0]            f;
        logic [63:0]           a, b;
        int                    cat;
        rst = 1'b1;
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_resp_zero", fu_resp == '0, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        issue(2, 3'b001, 64'd100, 64'd7, 0, -1, -1);                             // DIVU
        issue(0, 3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 10, -1, -1);            // REM -7/2
        issue(1, 3'b000, 64'd5, 64'd0, 1, -1, -1);                               // DIV by 0
        issue(3, 3'b011, 64'd5, 64'd0, 0, -1, -1);                               // REMU by 0
        issue(0, 3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2, -1, -1);
        issue(2, 3'b100, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1, -1);
        issue(0, 3'b101, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, -1, -1);             // DIVUW
        issue(0, 3'b000, 64'd1000, 64'hFFFF_FFFF_FFFF_FFFD, 1, 3, -1);           // lanes 0 and 3
        issue(1, 3'b011, 64'd123456789, 64'd1000, 0, -1, 0);                     // decoy on lane 0
        issue(0, 3'b110, 64'hDEAD_BEEF_FFFF_FFF9, 64'h0000_0000_0000_0002, 0, -1, -1); // REMW

        // A request presented while busy must be dropped.
        issue(0, 3'b001, 64'd99999, 64'd13, 0, -1, -1);
        r = '0;
        r[1] = mk(16'h8ABC, FUID, 3'b000, 7'd3, 64'd50, 64'd5);
        drive(r);

        // Reset mid-CALC abandons the operation.
        wait_idle();
        r = '0;
        r[0] = mk(16'h8123, FUID, 3'b000, 7'd1, 64'd12345, 64'd67);
        drive(r);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("busy_after_midreset", busy, 1'b0);
        chk("resp_after_midreset", fu_resp[0].opid[15], 1'b0);
        repeat (80) @(negedge clk);

        // Randomised operations.
        for (int n = 0; n < 40; n++) begin
            f   = 3'($urandom_range(0, 7));
            cat = $urandom_range(0, 5);
            case (cat)
                0: begin
                    a = 64'($urandom_range(0, 5000));
                    b = 64'($urandom_range(1, 100));
                    if ($urandom_range(0, 1) == 1) a = 64'd0 - a;
                    if ($urandom_range(0, 1) == 1) b = 64'd0 - b;
                end
                1: begin
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom};
                end
                2: begin
                    a = {$urandom, $urandom};
                    b = {32'($urandom), 32'd0};
                    if ($urandom_range(0, 1) == 1) b = 64'd0;
                end
                3: begin
                    a = ($urandom_range(0, 1) == 1) ? 64'h8000_0000_0000_0000
                                                    : {32'($urandom), 32'h8000_0000};
                    b = 64'hFFFF_FFFF_FFFF_FFFF;
                end
                default: begin
                    a = {$urandom, $urandom};
                    b = 64'($urandom_range(1, 65535));
                end
            endcase
            issue($urandom_range(0, EWD - 1), f, a, b, $urandom_range(0, 3), -1, -1);
        end

        wait_idle();
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
